// File: rtl/data_mem.sv
// Word-organised data memory with RISC-V byte/half/word access,
// a fixed response latency and misalignment/encoding fault detection.
module data_mem #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [2:0]          f3_q, f3_d;
    logic [1:0]          off_q, off_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [31:0]         mem_q [DEPTH];

    logic                accept;
    logic                fault;
    logic                commit;
    logic [31:0]         word;
    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;
    logic [31:0]         load_val;
    logic [3:0]          be;
    logic [31:0]         st_data;
    logic [31:0]         merged;
    logic                unused_addr;

    // Address bits above the word index are aliased away.
    assign unused_addr = ^addr[31:ADDR_W+2];

    assign accept = (state_q == S_IDLE) && req;

    // State register and captured request fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic: accept in IDLE, count down in WAIT, one RESP cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        f3_d    = f3_q;
        off_d   = off_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = we;
                    f3_d    = funct3;
                    off_d   = addr[1:0];
                    idx_d   = addr[ADDR_W+1:2];
                    wdata_d = wdata;
                    cnt_d   = CNT_INIT;
                    state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Fault decode on the captured access size and alignment.
    always_comb begin
        fault = 1'b1;
        unique case (f3_q)
            3'b000:  fault = 1'b0;
            3'b001:  fault = off_q[0];
            3'b010:  fault = (off_q != 2'b00);
            3'b100:  fault = we_q;
            3'b101:  fault = we_q | off_q[0];
            default: fault = 1'b1;
        endcase
    end

    // Load lane selection and sign/zero extension.
    always_comb begin
        word     = mem_q[idx_q];
        byte_sel = 8'(word >> {off_q, 3'b000});
        half_sel = off_q[1] ? word[31:16] : word[15:0];
        load_val = word;
        unique case (f3_q)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_val = {24'd0, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_val = {16'd0, half_sel};
            default: load_val = word;
        endcase
    end

    // Store byte enables and lane-replicated store data.
    always_comb begin
        be      = 4'b0000;
        st_data = wdata_q;
        unique case (f3_q)
            3'b000: begin
                be      = 4'b0001 << off_q;
                st_data = {4{wdata_q[7:0]}};
            end
            3'b001: begin
                be      = off_q[1] ? 4'b1100 : 4'b0011;
                st_data = {2{wdata_q[15:0]}};
            end
            3'b010: begin
                be      = 4'b1111;
                st_data = wdata_q;
            end
            default: begin
                be      = 4'b0000;
                st_data = wdata_q;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            merged[i*8 +: 8] = be[i] ? st_data[i*8 +: 8] : word[i*8 +: 8];
        end
    end

    // Response outputs; rdata is live in RESP and held afterwards.
    always_comb begin
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_RESP);
        err     = done & fault;
        commit  = done & we_q & ~fault;
        rdata   = rdata_q;
        if (done) begin
            if (fault) begin
                rdata = '0;
            end else if (!we_q) begin
                rdata = load_val;
            end
        end
        rdata_d = rdata;
    end

    // Memory array; cleared by reset, written on the edge ending RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (commit) begin
            mem_q[idx_q] <= merged;
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: latency-2 instance (ADDR_W=4)
// and a zero-latency instance driven with req held high.
module tb_data_mem;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    logic        clk;
    logic        rst_n;

    logic        req_a, we_a;
    logic [2:0]  f3_a;
    logic [31:0] addr_a, wdata_a;
    logic        busy_a, done_a, err_a;
    logic [31:0] rdata_a;

    logic        req_b, we_b;
    logic [2:0]  f3_b;
    logic [31:0] addr_b, wdata_b;
    logic        busy_b, done_b, err_b;
    logic [31:0] rdata_b;

    int          tests;
    int          fails;
    logic [31:0] last_rd;
    vec_t        vecs [21];

    data_mem #(.ADDR_W(4), .WAIT_CYCLES(2)) u_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .we(we_a),
        .funct3(f3_a), .addr(addr_a), .wdata(wdata_a),
        .busy(busy_a), .done(done_a), .err(err_a), .rdata(rdata_a)
    );

    data_mem #(.ADDR_W(10), .WAIT_CYCLES(0)) u_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .we(we_b),
        .funct3(f3_b), .addr(addr_b), .wdata(wdata_b),
        .busy(busy_b), .done(done_b), .err(err_b), .rdata(rdata_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Wait for done on u_a; returns negedges elapsed, 99 on timeout.
    task automatic wait_done_a(output int n);
        n = 99;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done_a) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic do_txn(input vec_t v, input string nm);
        int          n;
        logic [31:0] exp;
        exp = (v.we && !v.exp_err) ? last_rd : v.exp_rd;
        @(negedge clk);
        req_a   = 1'b1;
        we_a    = v.we;
        f3_a    = v.f3;
        addr_a  = v.addr;
        wdata_a = v.wdata;
        @(posedge clk);
        #1 req_a = 1'b0;
        wait_done_a(n);
        check({nm, "_lat"}, n, 3);
        check({nm, "_err"}, {31'd0, err_a}, {31'd0, v.exp_err});
        check({nm, "_rd"}, rdata_a, exp);
        @(negedge clk);
        check({nm, "_pulse"}, {30'd0, done_a, err_a}, 32'd0);
        check({nm, "_hold"}, rdata_a, exp);
        last_rd = exp;
    endtask

    initial begin
        int n;
        int pulses;
        tests   = 0;
        fails   = 0;
        last_rd = '0;

        vecs[0]  = '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 3'b000, 32'h13, 32'h00000080, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 32'hFFFFFF80};
        vecs[4]  = '{1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 32'h00000080};
        vecs[5]  = '{1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h80ADBEEF};
        vecs[6]  = '{1'b0, 3'b001, 32'h11, 32'h0, 1'b1, 32'h0};
        vecs[7]  = '{1'b1, 3'b010, 32'h12, 32'h11111111, 1'b1, 32'h0};
        vecs[8]  = '{1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h80ADBEEF};
        vecs[9]  = '{1'b1, 3'b001, 32'h16, 32'hBEEF1234, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 3'b001, 32'h16, 32'h0, 1'b0, 32'h00001234};
        vecs[11] = '{1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 32'hFFFF80AD};
        vecs[12] = '{1'b0, 3'b101, 32'h12, 32'h0, 1'b0, 32'h000080AD};
        vecs[13] = '{1'b1, 3'b100, 32'h14, 32'h000000FF, 1'b1, 32'h0};
        vecs[14] = '{1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0};
        vecs[15] = '{1'b0, 3'b000, 32'h10, 32'h0, 1'b0, 32'hFFFFFFEF};
        vecs[16] = '{1'b0, 3'b100, 32'h11, 32'h0, 1'b0, 32'h000000BE};
        vecs[17] = '{1'b1, 3'b010, 32'h40, 32'hAAAA5555, 1'b0, 32'h0};
        vecs[18] = '{1'b0, 3'b010, 32'h00, 32'h0, 1'b0, 32'hAAAA5555};
        vecs[19] = '{1'b0, 3'b010, 32'h14, 32'h0, 1'b0, 32'h12340000};
        vecs[20] = '{1'b0, 3'b110, 32'h10, 32'h0, 1'b1, 32'h0};

        rst_n = 1'b0;
        req_a = 1'b0; we_a = 1'b0; f3_a = '0; addr_a = '0; wdata_a = '0;
        req_b = 1'b0; we_b = 1'b0; f3_b = '0; addr_b = '0; wdata_b = '0;
        repeat (2) @(negedge clk);
        check("rst_a", {busy_a, done_a, err_a, rdata_a[28:0]}, 32'd0);
        check("rst_a_rd", rdata_a, 32'd0);
        check("rst_b", {29'd0, busy_b, done_b, err_b}, 32'd0);

        // Zero-latency instance, req raised together with reset release.
        rst_n   = 1'b1;
        req_b   = 1'b1;
        we_b    = 1'b1;
        f3_b    = 3'b010;
        addr_b  = 32'h8;
        wdata_b = 32'hCAFEF00D;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("b_done%0d", i), {31'd0, done_b},
                  {31'd0, (i % 2 == 0)});
            check($sformatf("b_busy%0d", i), {31'd0, busy_b},
                  {31'd0, (i % 2 == 0)});
            if (i == 0) begin
                check("b_st_rd", rdata_b, 32'd0);
                we_b = 1'b0;
            end
            if (i == 2) check("b_ld_rd", rdata_b, 32'hCAFEF00D);
        end
        req_b = 1'b0;

        for (int i = 0; i < 21; i++) begin
            do_txn(vecs[i], $sformatf("v%0d", i));
        end

        // req held high through WAIT/RESP is not queued.
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b0; f3_a = 3'b010; addr_a = 32'h0;
        @(posedge clk);
        wait_done_a(n);
        check("hold_lat", n, 3);
        check("hold_rd", rdata_a, 32'hAAAA5555);
        @(negedge clk);
        check("hold_idle", {31'd0, busy_a}, 32'd0);
        @(negedge clk);
        check("hold_acc", {31'd0, busy_a}, 32'd1);
        req_a = 1'b0;
        wait_done_a(n);
        check("hold_lat2", n, 2);
        repeat (2) @(negedge clk);
        check("hold_noq", {31'd0, busy_a}, 32'd0);

        // Reset during WAIT aborts the store.
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b1; f3_a = 3'b010;
        addr_a = 32'h20; wdata_a = 32'h12345678;
        @(posedge clk);
        #1 req_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {30'd0, busy_a, done_a}, 32'd0);
        check("abort_rd", rdata_a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_rd = '0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done_a) pulses++;
        end
        check("abort_nodone", pulses, 0);
        do_txn('{1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'h0}, "abort_ld");
        do_txn('{1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h0}, "clr_ld");

        // Reset during RESP blocks the commit.
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b1; f3_a = 3'b010;
        addr_a = 32'h24; wdata_a = 32'h55AA55AA;
        @(posedge clk);
        #1 req_a = 1'b0;
        wait_done_a(n);
        check("resp_lat", n, 3);
        rst_n = 1'b0;
        #1;
        check("resp_rst", {30'd0, done_a, busy_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_rd = '0;
        do_txn('{1'b0, 3'b010, 32'h24, 32'h0, 1'b0, 32'h0}, "resp_ld");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
